// File: rtl/bcd_result_converter.sv
// bcd_result_converter
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Sits behind the registered multiplier: captures the product on a start
// strobe, produces D packed BCD digits N clocks later, or an all-F error
// code one clock later when the multiplier flagged out-of-range.
//
// Handshake: start is a request sampled only while idle (busy=0); the edge
// that samples it is the accepting edge and raises busy. There is no
// back-pressure: start while busy is dropped. done is a one-cycle pulse on
// the result edge, and bcd/err_out hold that result until the next one.
//
// D must satisfy 10^D > 2^N so the accumulator cannot overflow.
module bcd_result_converter #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active-low
  input  logic           start,
  input  logic [N-1:0]   bin,
  input  logic           err,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           err_out,
  output logic [1:0]     dbg_state   // current FSM state for observation
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [N-1:0]   r_sr;       // binary bits still to be shifted in
  logic [4*D-1:0] r_acc;      // BCD digit accumulator
  logic [CW-1:0]  r_cnt;      // shifts remaining
  logic [4*D-1:0] r_bcd;
  logic           r_err_out;
  logic           r_done;

  logic [4*D-1:0] w_adj;      // accumulator after add-3 adjust
  logic [4*D-1:0] w_acc_next;
  logic [N-1:0]   w_sr_next;
  logic           w_last;     // this SHIFT cycle performs the Nth shift
  logic           w_accept;   // start accepted this edge

  // Add 3 to every digit that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < D; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_acc_next = {w_adj[4*D-2:0], r_sr[N-1]};
  assign w_sr_next  = {r_sr[N-2:0], 1'b0};
  assign w_last     = (r_cnt == CW'(1));
  assign w_accept   = (r_state == S_IDLE) && start;

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = err ? S_ERR : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next_state = S_IDLE;
        end
      end
      S_ERR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: load on accept, shift while converting, publish on result edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_err_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !err) begin
            r_sr  <= bin;
            r_acc <= '0;
            r_cnt <= CW'(N);
          end
        end
        S_SHIFT: begin
          r_sr  <= w_sr_next;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_bcd     <= w_acc_next;
            r_err_out <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        S_ERR: begin
          r_bcd     <= {(4*D){1'b1}};
          r_err_out <= 1'b1;
          r_done    <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign bcd       = r_bcd;
  assign err_out   = r_err_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed testbench for bcd_result_converter (N=8, D=3).
module tb_bcd_result_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        err;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        err_out;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  bcd_result_converter #(.N(8), .D(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .err       (err),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .err_out   (err_out),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request, let one edge accept it, then wait (bounded)
  // for done. lat = edges after the accepting edge until done (-1 on timeout);
  // busy_cnt = samples with busy high from the accepting edge up to done.
  task automatic run_conv(input logic [7:0] b, input logic e,
                          output int lat, output int busy_cnt);
    start = 1'b1;
    bin   = b;
    err   = e;
    @(posedge clk); #1;
    start    = 1'b0;
    bin      = 8'hXX;
    err      = 1'bx;
    busy_cnt = busy ? 1 : 0;
    lat      = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; bin = 8'd0; err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000)   begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    checks++; if (err_out !== 1'b0)  begin failures++; $display("FAIL reset_err_out got=%b exp=0", err_out); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat, bc;
    run_conv(8'd0, 1'b0, lat, bc);
    checks++; if (lat !== 8)          begin failures++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h000)    begin failures++; $display("FAIL zero_bcd got=%h exp=000", bcd); end
    checks++; if (err_out !== 1'b0)   begin failures++; $display("FAIL zero_err_out got=%b exp=0", err_out); end
  endtask

  task automatic test_values();
    logic [7:0]  vin [2];
    logic [11:0] vexp [2];
    int lat, bc;
    vin[0] = 8'd255; vexp[0] = 12'h255;
    vin[1] = 8'd51;  vexp[1] = 12'h051;
    for (int i = 0; i < 2; i++) begin
      run_conv(vin[i], 1'b0, lat, bc);
      checks++; if (lat !== 8)        begin failures++; $display("FAIL val%0d_latency got=%0d exp=8", i, lat); end
      checks++; if (bc !== 8)         begin failures++; $display("FAIL val%0d_busy_cycles got=%0d exp=8", i, bc); end
      checks++; if (bcd !== vexp[i])  begin failures++; $display("FAIL val%0d_bcd got=%h exp=%h", i, bcd, vexp[i]); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL val%0d_busy_at_done got=%b exp=0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)    begin failures++; $display("FAIL val%0d_done_width got=%b exp=0", i, done); end
      checks++; if (bcd !== vexp[i])  begin failures++; $display("FAIL val%0d_bcd_hold got=%h exp=%h", i, bcd, vexp[i]); end
    end
  endtask

  task automatic test_error();
    int lat, bc;
    run_conv(8'hFE, 1'b1, lat, bc);
    checks++; if (lat !== 1)          begin failures++; $display("FAIL err_latency got=%0d exp=1", lat); end
    checks++; if (bcd !== 12'hFFF)    begin failures++; $display("FAIL err_bcd got=%h exp=FFF", bcd); end
    checks++; if (err_out !== 1'b1)   begin failures++; $display("FAIL err_err_out got=%b exp=1", err_out); end
    checks++; if (bc !== 1)           begin failures++; $display("FAIL err_busy_cycles got=%0d exp=1", bc); end
    run_conv(8'd27, 1'b0, lat, bc);
    checks++; if (lat !== 8)          begin failures++; $display("FAIL after_err_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h027)    begin failures++; $display("FAIL after_err_bcd got=%h exp=027", bcd); end
    checks++; if (err_out !== 1'b0)   begin failures++; $display("FAIL after_err_err_out got=%b exp=0", err_out); end
  endtask

  task automatic test_start_while_busy();
    int ndone, done_at;
    logic [11:0] got;
    ndone = 0; done_at = -1; got = 12'h000;
    start = 1'b1; bin = 8'd200; err = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3);
      bin   = (c == 3) ? 8'd99 : 8'd0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        done_at = c;
        got = bcd;
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 1)        begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", ndone); end
    checks++; if (done_at !== 8)      begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=8", done_at); end
    checks++; if (got !== 12'h200)    begin failures++; $display("FAIL busy_start_bcd got=%h exp=200", got); end
  endtask

  task automatic test_reset_abort();
    int ndone, lat, bc;
    ndone = 0;
    start = 1'b1; bin = 8'd128; err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000)    begin failures++; $display("FAIL abort_bcd got=%h exp=000", bcd); end
    checks++; if (err_out !== 1'b0)   begin failures++; $display("FAIL abort_err_out got=%b exp=0", err_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0)        begin failures++; $display("FAIL abort_spurious_done got=%0d exp=0", ndone); end
    run_conv(8'd9, 1'b0, lat, bc);
    checks++; if (lat !== 8)          begin failures++; $display("FAIL abort_next_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h009)    begin failures++; $display("FAIL abort_next_bcd got=%h exp=009", bcd); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, t;
    logic [11:0] b1, b2;
    t1 = -1; t2 = -1; t = 0; b1 = 12'h000; b2 = 12'h000;
    start = 1'b1; bin = 8'd100; err = 1'b0;
    @(posedge clk); #1;
    while (t < 40 && t2 < 0) begin
      @(posedge clk); #1;
      t++;
      if (t1 >= 0 && t == t1 + 1) start = 1'b0;
      if (done) begin
        if (t1 < 0) begin
          t1 = t; b1 = bcd; bin = 8'd7;
        end else begin
          t2 = t; b2 = bcd;
        end
      end
    end
    start = 1'b0;
    checks++; if (t1 !== 8)           begin failures++; $display("FAIL b2b_first_latency got=%0d exp=8", t1); end
    checks++; if (b1 !== 12'h100)     begin failures++; $display("FAIL b2b_first_bcd got=%h exp=100", b1); end
    checks++; if (t2 - t1 !== 9)      begin failures++; $display("FAIL b2b_spacing got=%0d exp=9", t2 - t1); end
    checks++; if (b2 !== 12'h007)     begin failures++; $display("FAIL b2b_second_bcd got=%h exp=007", b2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_zero();
    test_values();
    test_error();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
